// File: rtl/core_pkg.sv
// Shared core definitions: write-back select encodings, load/store funct3 codes,
// data RAM default depth, and the MEM/WB pipeline register layout.
package core_pkg;

  localparam int unsigned DMEM_DEPTH = 1024;

  // Write-back result select
  localparam logic [2:0] RESULT_ALU = 3'b000;
  localparam logic [2:0] RESULT_MEM = 3'b001;
  localparam logic [2:0] RESULT_PC4 = 3'b010;
  localparam logic [2:0] RESULT_IMM = 3'b011;

  // Load/store width and sign
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Contents of the MEM/WB register
  typedef struct packed {
    logic        live;        // 0 only while the register holds its reset value
    logic        reg_write;
    logic [2:0]  result_src;
    logic [31:0] alu_result;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
    logic [31:0] immext;
    logic [1:0]  offset;
    logic [2:0]  funct3;
    logic        misaligned;
    logic        is_load;
    logic        is_store;
  } mem_wb_t;

  // Halfwords need an even offset, words a zero offset; other widths never fault.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    return ((funct3[1:0] == 2'b01) && offset[0]) ||
           ((funct3[1:0] == 2'b10) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_sync.sv
// Byte-enable synchronous data RAM with a registered read port.
// Ports: clk; we[3:0] per-byte write enables; addr word address; wdata write word;
// rdata word read at the previous edge (read-before-write on the same address).
module dmem_sync #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // Power-up contents are zero; reset never touches the array.
  logic [31:0] mem_q [DEPTH] = '{default: '0};
  logic [31:0] rdata_q = '0;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage plus MEM/WB register. Generates store lanes into dmem_sync,
// extracts and extends load data in W, and muxes the write-back result.
// Inputs: M-stage control/data (reg_writeM, result_srcM, mem_writeM, alu_resultM,
// rd2_M, write_dataM = rd index, PC_PLUS4M, immext_M, funct_3m).
// Outputs: registered W-stage copies, aligned read_dataW, misalign_W, resultW.
module mem_wb_stage
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_writeM,
  input  logic [2:0]  result_srcM,
  input  logic        mem_writeM,
  input  logic [31:0] alu_resultM,
  input  logic [31:0] rd2_M,
  input  logic [4:0]  write_dataM,
  input  logic [31:0] PC_PLUS4M,
  input  logic [31:0] immext_M,
  input  logic [2:0]  funct_3m,
  output logic        reg_writeW,
  output logic [2:0]  result_srcW,
  output logic [31:0] alu_resultW,
  output logic [31:0] read_dataW,
  output logic [4:0]  write_dataW,
  output logic [31:0] PC_PLUS4W,
  output logic [31:0] immext_W,
  output logic        misalign_W,
  output logic [31:0] resultW
);

  logic [1:0]    offset;
  logic [AW-1:0] word_addr;
  logic          misaligned;
  logic [3:0]    ram_we;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  mem_wb_t       w_d;
  mem_wb_t       w_q = '0;

  assign offset     = alu_resultM[1:0];
  assign word_addr  = alu_resultM[AW+1:2];
  assign misaligned = is_misaligned(funct_3m, offset);

  // Store lane enables and lane-replicated data
  always_comb begin
    ram_we    = 4'b0000;
    ram_wdata = rd2_M;
    case (funct_3m)
      F3_B:    ram_wdata = {4{rd2_M[7:0]}};
      F3_H:    ram_wdata = {2{rd2_M[15:0]}};
      default: ram_wdata = rd2_M;
    endcase
    if (mem_writeM && !misaligned && !reset) begin
      case (funct_3m)
        F3_B:    ram_we = 4'b0001 << offset;
        F3_H:    ram_we = offset[1] ? 4'b1100 : 4'b0011;
        F3_W:    ram_we = 4'b1111;
        default: ram_we = 4'b0000;
      endcase
    end
  end

  dmem_sync #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_dmem (
    .clk  (clk),
    .we   (ram_we),
    .addr (word_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_comb begin
    w_d            = '0;
    w_d.live       = 1'b1;
    w_d.reg_write  = reg_writeM;
    w_d.result_src = result_srcM;
    w_d.alu_result = alu_resultM;
    w_d.rd         = write_dataM;
    w_d.pc_plus4   = PC_PLUS4M;
    w_d.immext     = immext_M;
    w_d.offset     = offset;
    w_d.funct3     = funct_3m;
    w_d.misaligned = misaligned;
    w_d.is_load    = (result_srcM == RESULT_MEM);
    w_d.is_store   = mem_writeM;
  end

  always_ff @(posedge clk) begin
    if (reset) w_q <= '0;
    else       w_q <= w_d;
  end

  // The RAM output register has no reset; masking it with live makes the
  // load word read as zero right after reset.
  logic [31:0] load_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign load_word = w_q.live ? ram_rdata : 32'h0;
  assign byte_sel  = load_word[{w_q.offset, 3'b000} +: 8];
  assign half_sel  = w_q.offset[1] ? load_word[31:16] : load_word[15:0];

  always_comb begin
    case (w_q.funct3)
      F3_B:    read_dataW = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    read_dataW = {{16{half_sel[15]}}, half_sel};
      F3_W:    read_dataW = load_word;
      F3_BU:   read_dataW = {24'h0, byte_sel};
      F3_HU:   read_dataW = {16'h0, half_sel};
      default: read_dataW = 32'h0;
    endcase
  end

  always_comb begin
    case (w_q.result_src)
      RESULT_ALU: resultW = w_q.alu_result;
      RESULT_MEM: resultW = read_dataW;
      RESULT_PC4: resultW = w_q.pc_plus4;
      RESULT_IMM: resultW = w_q.immext;
      default:    resultW = w_q.alu_result;
    endcase
  end

  assign reg_writeW  = w_q.reg_write & ~(w_q.misaligned & w_q.is_load);
  assign misalign_W  = w_q.misaligned & (w_q.is_load | w_q.is_store);
  assign result_srcW = w_q.result_src;
  assign alu_resultW = w_q.alu_result;
  assign write_dataW = w_q.rd;
  assign PC_PLUS4W   = w_q.pc_plus4;
  assign immext_W    = w_q.immext;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_writeM;
  logic [2:0]  result_srcM;
  logic        mem_writeM;
  logic [31:0] alu_resultM;
  logic [31:0] rd2_M;
  logic [4:0]  write_dataM;
  logic [31:0] PC_PLUS4M;
  logic [31:0] immext_M;
  logic [2:0]  funct_3m;
  logic        reg_writeW;
  logic [2:0]  result_srcW;
  logic [31:0] alu_resultW;
  logic [31:0] read_dataW;
  logic [4:0]  write_dataW;
  logic [31:0] PC_PLUS4W;
  logic [31:0] immext_W;
  logic        misalign_W;
  logic [31:0] resultW;

  always #5 clk = ~clk;

  mem_wb_stage #(.DEPTH(1024)) dut (
    .clk        (clk),
    .reset      (reset),
    .reg_writeM (reg_writeM),
    .result_srcM(result_srcM),
    .mem_writeM (mem_writeM),
    .alu_resultM(alu_resultM),
    .rd2_M      (rd2_M),
    .write_dataM(write_dataM),
    .PC_PLUS4M  (PC_PLUS4M),
    .immext_M   (immext_M),
    .funct_3m   (funct_3m),
    .reg_writeW (reg_writeW),
    .result_srcW(result_srcW),
    .alu_resultW(alu_resultW),
    .read_dataW (read_dataW),
    .write_dataW(write_dataW),
    .PC_PLUS4W  (PC_PLUS4W),
    .immext_W   (immext_W),
    .misalign_W (misalign_W),
    .resultW    (resultW)
  );

  typedef struct {
    logic        rst;
    logic        rw;
    logic [2:0]  src;
    logic        mw;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic        e_rw;
    logic        e_mis;
    logic [31:0] e_res;
    logic        chk_rd;
    logic [31:0] e_rd;
  } vec_t;

  typedef struct {
    int           id;
    logic         e_rw;
    logic         e_mis;
    logic [31:0]  e_res;
    logic         chk_rd;
    logic [31:0]  e_rd;
    logic [103:0] e_pass;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic rst, rw, input logic [2:0] src, input logic mw,
                              input logic [31:0] alu, rd2, input logic [2:0] f3,
                              input logic e_rw, e_mis, input logic [31:0] e_res,
                              input logic chk, input logic [31:0] e_rd);
    vec_t v;
    v.rst = rst; v.rw = rw; v.src = src; v.mw = mw; v.alu = alu; v.rd2 = rd2;
    v.pc4 = 32'h0; v.imm = 32'h0; v.f3 = f3;
    v.e_rw = e_rw; v.e_mis = e_mis; v.e_res = e_res; v.chk_rd = chk; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic cmp(input string name, input int id, input logic [103:0] act,
                     input logic [103:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec %0d: got %0h want %0h", name, id, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got 0 entries want 1");
      return;
    end
    e = sb_q.pop_front();
    cmp("reg_writeW", e.id, 104'(reg_writeW), 104'(e.e_rw));
    cmp("misalign_W", e.id, 104'(misalign_W), 104'(e.e_mis));
    cmp("resultW", e.id, 104'(resultW), 104'(e.e_res));
    cmp("w_regs", e.id, {result_srcW, alu_resultW, write_dataW, PC_PLUS4W, immext_W},
        e.e_pass);
    if (e.chk_rd) cmp("read_dataW", e.id, 104'(read_dataW), 104'(e.e_rd));
  endtask

  // Drive one M-stage instruction, queue its expectation, compare one cycle later.
  task automatic apply(input vec_t v, input int id);
    exp_t        e;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic [31:0] imm;
    rd  = 5'((id * 3 + 1) % 32);
    pc4 = (v.pc4 != 32'h0) ? v.pc4 : 32'h1000 + 32'(id * 4);
    imm = (v.imm != 32'h0) ? v.imm : 32'h7000_0000 + 32'(id);
    reset       = v.rst;
    reg_writeM  = v.rw;
    result_srcM = v.src;
    mem_writeM  = v.mw;
    alu_resultM = v.alu;
    rd2_M       = v.rd2;
    write_dataM = rd;
    PC_PLUS4M   = pc4;
    immext_M    = imm;
    funct_3m    = v.f3;
    e.id     = id;
    e.e_rw   = v.e_rw;
    e.e_mis  = v.e_mis;
    e.e_res  = v.e_res;
    e.chk_rd = v.chk_rd;
    e.e_rd   = v.e_rd;
    e.e_pass = v.rst ? 104'h0 : {v.src, v.alu, rd, pc4, imm};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  vec_t tbl[32];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //               rst rw src     mw alu            rd2            f3      e_rw e_mis e_res         chk e_rd
    tbl[0]  = mk(1, 1, 3'b001, 1, 32'h10,       32'hFFFF_FFFF, 3'b010, 0, 0, 32'h0,         1, 32'h0);
    tbl[1]  = mk(0, 0, 3'b000, 1, 32'h10,       32'hDEAD_BEEF, 3'b010, 0, 0, 32'h10,        0, 32'h0);
    tbl[2]  = mk(0, 1, 3'b001, 0, 32'h10,       32'h0,         3'b010, 1, 0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
    tbl[3]  = mk(0, 0, 3'b000, 1, 32'h13,       32'h1234_5680, 3'b000, 0, 0, 32'h13,        0, 32'h0);
    tbl[4]  = mk(0, 1, 3'b001, 0, 32'h13,       32'h0,         3'b000, 1, 0, 32'hFFFF_FF80, 1, 32'hFFFF_FF80);
    tbl[5]  = mk(0, 1, 3'b001, 0, 32'h13,       32'h0,         3'b100, 1, 0, 32'h80,        1, 32'h80);
    tbl[6]  = mk(0, 1, 3'b001, 0, 32'h10,       32'h0,         3'b010, 1, 0, 32'h80AD_BEEF, 1, 32'h80AD_BEEF);
    tbl[7]  = mk(0, 0, 3'b000, 1, 32'h12,       32'hAAAA_1234, 3'b001, 0, 0, 32'h12,        0, 32'h0);
    tbl[8]  = mk(0, 1, 3'b001, 0, 32'h12,       32'h0,         3'b101, 1, 0, 32'h1234,      1, 32'h1234);
    tbl[9]  = mk(0, 1, 3'b001, 0, 32'h10,       32'h0,         3'b001, 1, 0, 32'hFFFF_BEEF, 1, 32'hFFFF_BEEF);
    tbl[10] = mk(0, 1, 3'b001, 0, 32'h11,       32'h0,         3'b010, 0, 1, 32'h1234_BEEF, 1, 32'h1234_BEEF);
    tbl[11] = mk(0, 0, 3'b000, 1, 32'h11,       32'hFFFF_FFFF, 3'b010, 0, 1, 32'h11,        0, 32'h0);
    tbl[12] = mk(0, 1, 3'b001, 0, 32'h10,       32'h0,         3'b010, 1, 0, 32'h1234_BEEF, 1, 32'h1234_BEEF);
    tbl[13] = mk(0, 1, 3'b000, 0, 32'h55AA,     32'h0,         3'b000, 1, 0, 32'h55AA,      0, 32'h0);
    tbl[14] = mk(0, 1, 3'b010, 0, 32'h55AA,     32'h0,         3'b000, 1, 0, 32'h104,       0, 32'h0);
    tbl[15] = mk(0, 1, 3'b011, 0, 32'h55AA,     32'h0,         3'b000, 1, 0, 32'hABCD_E000, 0, 32'h0);
    tbl[16] = mk(0, 0, 3'b000, 1, 32'h20,       32'h1122_3344, 3'b010, 0, 0, 32'h20,        0, 32'h0);
    tbl[17] = mk(1, 1, 3'b000, 1, 32'h20,       32'h55,        3'b010, 0, 0, 32'h0,         1, 32'h0);
    tbl[18] = mk(0, 1, 3'b001, 0, 32'h20,       32'h0,         3'b010, 1, 0, 32'h1122_3344, 1, 32'h1122_3344);
    tbl[19] = mk(0, 1, 3'b001, 0, 32'h8000_1010, 32'h0,        3'b010, 1, 0, 32'h1234_BEEF, 1, 32'h1234_BEEF);
    tbl[20] = mk(0, 0, 3'b000, 1, 32'h21,       32'h0000_00C3, 3'b000, 0, 0, 32'h21,        0, 32'h0);
    tbl[21] = mk(0, 1, 3'b001, 0, 32'h20,       32'h0,         3'b010, 1, 0, 32'h1122_C344, 1, 32'h1122_C344);
    tbl[22] = mk(0, 1, 3'b001, 0, 32'h22,       32'h0,         3'b001, 1, 0, 32'h1122,      1, 32'h1122);
    tbl[23] = mk(0, 1, 3'b001, 0, 32'h23,       32'h0,         3'b101, 0, 1, 32'h1122,      1, 32'h1122);
    tbl[24] = mk(0, 1, 3'b001, 0, 32'h20,       32'h0,         3'b011, 1, 0, 32'h0,         1, 32'h0);
    tbl[25] = mk(0, 0, 3'b000, 0, 32'h0,        32'h0,         3'b000, 0, 0, 32'h0,         0, 32'h0);
    tbl[26] = mk(0, 0, 3'b000, 1, 32'h20,       32'h0000_BEEF, 3'b001, 0, 0, 32'h20,        0, 32'h0);
    tbl[27] = mk(0, 1, 3'b001, 0, 32'h20,       32'h0,         3'b001, 1, 0, 32'hFFFF_BEEF, 1, 32'hFFFF_BEEF);
    tbl[28] = mk(0, 0, 3'b000, 1, 32'h20,       32'h0,         3'b100, 0, 0, 32'h20,        0, 32'h0);
    tbl[29] = mk(0, 1, 3'b001, 0, 32'h20,       32'h0,         3'b010, 1, 0, 32'h1122_BEEF, 1, 32'h1122_BEEF);
    tbl[30] = mk(0, 0, 3'b000, 1, 32'h21,       32'h0,         3'b001, 0, 1, 32'h21,        0, 32'h0);
    tbl[31] = mk(0, 1, 3'b001, 0, 32'h20,       32'h0,         3'b010, 1, 0, 32'h1122_BEEF, 1, 32'h1122_BEEF);
    tbl[14].pc4 = 32'h104;
    tbl[15].imm = 32'hABCD_E000;

    reset = 1'b1; reg_writeM = 1'b0; result_srcM = 3'b000; mem_writeM = 1'b0;
    alu_resultM = 32'h0; rd2_M = 32'h0; write_dataM = 5'h0; PC_PLUS4M = 32'h0;
    immext_M = 32'h0; funct_3m = 3'b000;
    @(posedge clk);
    #1;

    for (int i = 0; i < 32; i++) apply(tbl[i], i);

    // Wrapped store, then reset held two cycles over stores to the same word.
    apply(mk(0, 0, 3'b000, 1, 32'h1030, 32'hCAFE_F00D, 3'b010, 0, 0, 32'h1030, 0, 32'h0), 100);
    apply(mk(0, 1, 3'b001, 0, 32'h30,   32'h0,         3'b010, 1, 0, 32'hCAFE_F00D, 1,
             32'hCAFE_F00D), 101);
    apply(mk(1, 1, 3'b001, 1, 32'h30,   32'h0,         3'b010, 0, 0, 32'h0, 1, 32'h0), 102);
    apply(mk(1, 1, 3'b000, 1, 32'h31,   32'h0,         3'b000, 0, 0, 32'h0, 1, 32'h0), 103);
    apply(mk(0, 1, 3'b001, 0, 32'h33,   32'h0,         3'b000, 1, 0, 32'hFFFF_FFCA, 1,
             32'hFFFF_FFCA), 104);
    apply(mk(0, 1, 3'b001, 0, 32'h32,   32'h0,         3'b001, 1, 0, 32'hFFFF_CAFE, 1,
             32'hFFFF_CAFE), 105);
    apply(mk(0, 1, 3'b001, 0, 32'h30,   32'h0,         3'b010, 1, 0, 32'hCAFE_F00D, 1,
             32'hCAFE_F00D), 106);

    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register for the five-stage RISC-V core. Consumes the M-stage outputs of the EX/MEM register, performs byte/half/word stores into a local synchronous data RAM, reads load data, and presents registered W-stage signals plus the final write-back result to the register file. Sits between the EX/MEM register and the register-file write port.

## Interface

- DEPTH, 1024, data RAM size in 32-bit words; power of two
- AW, $clog2(DEPTH), word-address width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- reg_writeM  in  1  register-file write enable from M stage
- result_srcM  in  3  write-back select from M stage
- mem_writeM  in  1  store enable
- alu_resultM  in  32  byte address for memory ops; ALU result otherwise
- rd2_M  in  32  store data
- write_dataM  in  5  destination register index
- PC_PLUS4M  in  32  PC+4 of the M-stage instruction
- immext_M  in  32  extended immediate
- funct_3m  in  3  load/store width and sign
- reg_writeW  out  1  gated register-file write enable
- result_srcW  out  3  registered result_srcM
- alu_resultW  out  32  registered alu_resultM
- read_dataW  out  32  aligned, extended load data
- write_dataW  out  5  registered destination index
- PC_PLUS4W  out  32  registered PC_PLUS4M
- immext_W  out  32  registered immext_M
- misalign_W  out  1  W-stage instruction made a misaligned access
- resultW  out  32  write-back value

## Operation

- Word index = alu_resultM[AW+1:2]; byte offset = alu_resultM[1:0].
- Memory access: result_srcM == 3'b001 (load) or mem_writeM == 1 (store).
- Misaligned access: funct_3m[1:0] == 01 with offset[0] == 1, or funct_3m[1:0] == 10 with offset != 0.
- Stores: funct_3m 000 SB writes one lane, rd2_M[7:0] replicated. 001 SH writes lanes {offset[1],0} and {offset[1],1}, data rd2_M[15:0]. 010 SW writes all four lanes. Other funct_3m values write nothing.
- A misaligned store writes nothing. A store under reset writes nothing.
- Loads: the RAM word is read every cycle into a registered word. The W stage selects bytes from the registered offset and funct3:
  - 000 LB sign-extends.
  - 001 LH sign-extends, using half offset[1].
  - 010 LW.
  - 100 LBU zero-extends.
  - 101 LHU zero-extends.
  - Any other value returns 0.
- reg_writeW = registered reg_writeM AND NOT (registered misaligned AND registered load).
- misalign_W = registered misaligned AND (registered load OR registered store).
- resultW, combinational from W registers:
  - 000 alu_resultW
  - 001 read_dataW
  - 010 PC_PLUS4W
  - 011 immext_W
  - others alu_resultW
- Addresses beyond DEPTH words wrap modulo DEPTH; upper address bits are ignored.

## Timing

- Latency is one cycle from M inputs to all W outputs, including read_dataW.
- The RAM write commits at the edge that captures the store into W.
  - A load in the next cycle to the same word returns the new data.
  - No same-cycle read/write conflict exists: there is one instruction per stage.
- Reset, synchronous: every W-stage register clears to 0 on the next edge. This covers reg_writeW, result_srcW, alu_resultW, the internal load word/offset/funct3 registers, write_dataW, PC_PLUS4W, immext_W and misalign_W. As a result read_dataW = 0 and resultW = 0.
- RAM contents are not cleared by reset. They are initialised to zero at power-up, and all registers are also given zero initial values.
- Reset with a store in M: the store is dropped and W is cleared.
- The block has no stall or flush. Bubbles arrive as all-zero control from EX/MEM and produce reg_writeW = 0 with no memory write.

## Structure

- Shared package (core_pkg) holds:
  - RESULT_ALU/MEM/PC4/IMM encodings.
  - funct3 constants F3_B/H/W/BU/HU.
  - The DEPTH default.
- One sub-module, dmem_sync: byte-enable synchronous RAM with ports clk, we[3:0], addr[AW-1:0], wdata[31:0], rdata[31:0] (registered).
- The store lane/enable generation, load extraction and W register live in mem_wb_stage.

## Test plan

- SW 0xDEADBEEF at 0x10, then LW 0x10 → read_dataW = 0xDEADBEEF, resultW = 0xDEADBEEF, reg_writeW = 1.
- SB 0x80 at 0x13, then LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080; the word at 0x10 reads 0x80ADBEEF.
- SH 0x1234 at 0x12, then LHU 0x12 → 0x00001234; LH 0x10 → 0xFFFFBEEF.
- LW 0x11 with reg_writeM = 1 → misalign_W = 1, reg_writeW = 0. SW 0x11 → misalign_W = 1 and memory unchanged.
- result_srcM 010 / PC_PLUS4M 0x104 → resultW = 0x104 one cycle later; result_srcM 011 / immext_M 0xABCDE000 → resultW = 0xABCDE000.
- SW 0x55 at 0x20 with reset = 1 → next cycle all W outputs are 0, and LW 0x20 returns the prior contents.
